// File: rtl/bc_pkg.sv
// Shared constants for the basic-computer I/O and interrupt controller.
package bc_pkg;

  localparam int unsigned CHAR_W_DEF = 8;
  localparam int unsigned AC_W_DEF   = 16;
  localparam int unsigned IR_IO_W    = 6;

  // I/O instruction bit positions in IR.
  localparam int unsigned INP_B = 11;
  localparam int unsigned OUT_B = 10;
  localparam int unsigned SKI_B = 9;
  localparam int unsigned SKO_B = 8;
  localparam int unsigned ION_B = 7;
  localparam int unsigned IOF_B = 6;

  // Offsets of the same bits within ir_io (IR[11:6]).
  localparam int unsigned IR_IO_LSB = 6;
  localparam int unsigned INP_O = INP_B - IR_IO_LSB;
  localparam int unsigned OUT_O = OUT_B - IR_IO_LSB;
  localparam int unsigned SKI_O = SKI_B - IR_IO_LSB;
  localparam int unsigned SKO_O = SKO_B - IR_IO_LSB;
  localparam int unsigned ION_O = ION_B - IR_IO_LSB;
  localparam int unsigned IOF_O = IOF_B - IR_IO_LSB;

  localparam logic FGO_RST = 1'b1;
  localparam logic FGI_RST = 1'b0;

  // True when exactly one I/O opcode bit is set.
  function automatic logic is_onehot(input logic [IR_IO_W-1:0] v);
    return (v != '0) && ((v & (v - IR_IO_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/bc_io_chan.sv
// One character channel: a flag flip-flop plus a character register.
module bc_io_chan
  import bc_pkg::*;
#(
  parameter int unsigned CHAR_W   = CHAR_W_DEF,
  parameter logic        FLAG_RST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_flag,
  input  logic              clr_flag,
  input  logic              load,
  input  logic [CHAR_W-1:0] data_in,
  output logic              flag,
  output logic [CHAR_W-1:0] data
);

  // Flag and data register; a device-side set wins over an instruction-side clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag <= FLAG_RST;
      data <= '0;
    end else begin
      if (load) begin
        data <= data_in;
      end
      if (set_flag) begin
        flag <= 1'b1;
      end else if (clr_flag) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bc_io_intr_ctrl.sv
// I/O flags, character registers, interrupt enable and interrupt flip-flop.
module bc_io_intr_ctrl
  import bc_pkg::*;
#(
  parameter int unsigned CHAR_W = CHAR_W_DEF,
  parameter int unsigned AC_W   = AC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [CHAR_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [CHAR_W-1:0]  out_data,
  input  logic               out_ready,
  input  logic               io_exec,
  input  logic [IR_IO_W-1:0] ir_io,
  input  logic [AC_W-1:0]    ac_in,
  output logic [CHAR_W-1:0]  inpr,
  output logic               inp_load,
  output logic               skip,
  input  logic               instr_end,
  input  logic               int_ack,
  output logic               R,
  output logic               IEN,
  output logic               FGI,
  output logic               FGO
);

  logic dec_ok;
  logic do_inp;
  logic do_out_wr;
  logic do_ion;
  logic do_iof;
  logic in_hs;
  logic out_hs;
  logic unused_ac;

  assign unused_ac = ^ac_in[AC_W-1:CHAR_W];

  // Instruction decode; a non-one-hot opcode field decodes to nothing.
  always_comb begin
    dec_ok    = io_exec && is_onehot(ir_io);
    do_inp    = 1'b0;
    do_out_wr = 1'b0;
    do_ion    = 1'b0;
    do_iof    = 1'b0;
    skip      = 1'b0;
    if (dec_ok) begin
      do_inp    = ir_io[INP_O];
      do_out_wr = ir_io[OUT_O] && FGO;
      do_ion    = ir_io[ION_O];
      do_iof    = ir_io[IOF_O];
      skip      = (ir_io[SKI_O] && FGI) || (ir_io[SKO_O] && FGO);
    end
  end

  assign inp_load  = do_inp;
  assign in_ready  = ~FGI;
  assign out_valid = ~FGO;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  bc_io_chan #(.CHAR_W(CHAR_W), .FLAG_RST(FGI_RST)) u_in_chan (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_flag (in_hs),
    .clr_flag (do_inp),
    .load     (in_hs),
    .data_in  (in_data),
    .flag     (FGI),
    .data     (inpr)
  );

  bc_io_chan #(.CHAR_W(CHAR_W), .FLAG_RST(FGO_RST)) u_out_chan (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_flag (out_hs),
    .clr_flag (do_out_wr),
    .load     (do_out_wr),
    .data_in  (ac_in[CHAR_W-1:0]),
    .flag     (FGO),
    .data     (out_data)
  );

  // Interrupt enable and request; acknowledge overrides both set paths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R   <= 1'b0;
      IEN <= 1'b0;
    end else if (int_ack) begin
      R   <= 1'b0;
      IEN <= 1'b0;
    end else begin
      if (instr_end && IEN && (FGI || FGO)) begin
        R <= 1'b1;
      end
      if (do_ion) begin
        IEN <= 1'b1;
      end else if (do_iof) begin
        IEN <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bc_io_intr_ctrl.md
Name: bc_io_intr_ctrl

Overview:
- I/O and interrupt controller for the basic computer.
- Owns the input/output flag flip-flops FGI/FGO, the INPR/OUTR character registers, the interrupt enable IEN and the interrupt flip-flop R.
- Exchanges characters with external keyboard/printer models over valid/ready handshakes.
- Serves the six I/O instructions (INP, OUT, SKI, SKO, ION, IOF) for the CONTROLLER, and raises R so the CONTROLLER enters the interrupt cycle.

Parameters:
- CHAR_W, 8, width of INPR/OUTR and of the AC slice used by INP/OUT.
- AC_W, 16, accumulator width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  keyboard presents a character.
- in_data  in  CHAR_W  keyboard character.
- in_ready  out  1  block can accept a character; equals ~FGI.
- out_valid  out  1  character pending for printer; equals ~FGO.
- out_data  out  CHAR_W  OUTR contents.
- out_ready  in  1  printer accepts the character.
- io_exec  in  1  one-cycle strobe from CONTROLLER: I/O instruction executing (D7·I·T3).
- ir_io  in  6  IR[11:6]; one-hot: bit5=INP, bit4=OUT, bit3=SKI, bit2=SKO, bit1=ION, bit0=IOF.
- ac_in  in  AC_W  current AC, used by OUT.
- inpr  out  CHAR_W  INPR contents, for AC[7:0] load.
- inp_load  out  1  CONTROLLER loads inpr into AC[7:0] this cycle.
- skip  out  1  CONTROLLER increments PC this cycle.
- instr_end  in  1  strobe: last cycle of a non-interrupt instruction (SC clears next edge).
- int_ack  in  1  strobe: CONTROLLER in RT2 (final interrupt-cycle step).
- R  out  1  interrupt flip-flop; CONTROLLER branches to interrupt cycle when set at T0.
- IEN  out  1  interrupt enable.
- FGI  out  1  input flag.
- FGO  out  1  output flag.

Behaviour:
- Reset (rst_n=0 at edge): FGI=0, FGO=1, IEN=0, R=0, INPR=0, OUTR=0. All handshake and strobe outputs follow combinationally, so in_ready=1, out_valid=0, inp_load=0, skip=0.
- Reset mid-transfer discards a pending character and the OUTR contents.
- Input channel:
  - in_valid & in_ready at an edge: INPR<=in_data, FGI<=1.
  - While FGI=1, in_ready=0 and in_data is ignored.
- Output channel:
  - out_valid & out_ready at an edge: FGO<=1.
  - out_data is stable while out_valid=1.
- Decode: active only while io_exec=1.
  - If ir_io is not one-hot (zero or multiple bits set), the whole instruction is a NOP: no strobes, no state change.
- INP:
  - inp_load=1 combinationally in the same cycle.
  - Edge: FGI<=0. The same edge can accept a new character only if FGI was already 0, since in_ready is ~FGI of the current cycle.
- OUT:
  - If FGO=1: edge OUTR<=ac_in[CHAR_W-1:0], FGO<=0; out_valid rises the next cycle.
  - If FGO=0: write dropped; OUTR and FGO unchanged. Software contract is SKO before OUT.
- SKI: skip=FGI, combinational, same cycle.
- SKO: skip=FGO, combinational, same cycle.
- ION: edge IEN<=1.
- IOF: edge IEN<=0.
- Interrupt:
  - At an edge with instr_end=1 and IEN=1 and (FGI|FGO)=1: R<=1.
  - Flag/IEN values used are those of the current cycle, before that edge's updates.
  - int_ack=1: edge R<=0 and IEN<=0. int_ack has priority over an R set, and over ION in the same cycle.
- R is only ever set at instr_end, never mid-instruction.
- ION on the final cycle of its own instruction does not raise R on that edge; R can rise at the end of the next instruction.
- Latency:
  - Device handshake to FGI/FGO update: 1 edge.
  - Instruction strobes (inp_load, skip): 0 cycles.
  - Flag/IEN/OUTR effects: 1 edge.
- Simultaneous events:
  - OUT (FGO=0 → dropped) with printer accept: FGO<=1.
  - INP with FGI=0: inp_load still pulses (stale INPR), FGI stays 0.

Decomposition:
- Package bc_pkg holds:
  - IR I/O bit indices (INP_B=11 … IOF_B=6) and their ir_io offsets;
  - reset constants FGO_RST=1, FGI_RST=0;
  - CHAR_W default.
- One sub-module, bc_io_chan, instantiated twice (input and output channel). It holds:
  - a flag register with parameterised reset value;
  - a CHAR_W data register;
  - load-on-handshake and clear/set-on-instruction logic.
- The interrupt and decode logic stays in bc_io_intr_ctrl.

Test Plan:
1. Reset sequence, then keyboard sends 0x41 → FGI=1 next cycle, in_ready=0. SKI in io_exec gives skip=1. INP gives inp_load=1 with inpr=0x41, then FGI=0.
2. ac_in=0x1234, FGO=1, OUT → out_data=0x34, out_valid=1, FGO=0. Hold out_ready=0 for 3 cycles, then 1 → FGO=1, out_valid=0. A second OUT while FGO=0 (ac_in=0x0055) leaves out_data=0x34.
3. ION, then keyboard char 0x0D, then instr_end → R=1 after the edge. Assert int_ack → R=0, IEN=0. A later instr_end with FGI=1 leaves R=0.
4. IEN=0, FGO=1, instr_end pulses → R stays 0. ION with instr_end in the same cycle → R=0 after the edge. Next instr_end → R=1.
5. io_exec with ir_io=6'b100100 (INP+SKO) → inp_load=0, skip=0, no flag change. ir_io=0 → no effect.
6. rst_n=0 while out_valid=1 and R=1 → next cycle FGO=1, out_valid=0, R=0, IEN=0, INPR=0.
